// File: rtl/wallace_sum_sequencer.sv
// Streaming packet summer: batches 8-bit operands into groups of six, reduces each
// group through a registered six-operand Wallace tree and accumulates the group sums.

module wallace_tree (
    input  logic [7:0][5:0] x,   // x[b][k] = bit b of operand k
    output logic [10:0]     s
);
    // 6 * 255 = 1530 needs 11 bits.
    localparam int W = 11;

    logic [W-1:0] op [6];
    logic [W-1:0] s1a, c1a, s1b, c1b, s2, c2, s3, c3;

    function automatic logic [2*W-1:0] csa(input logic [W-1:0] a, b, c);
        logic [W-1:0] sum;
        logic [W-1:0] cy;
        sum = a ^ b ^ c;
        cy  = ((a & b) | (a & c) | (b & c)) << 1;
        return {cy, sum};
    endfunction

    // NOTE: every variable written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            op[k] = '0;
            for (int b = 0; b < 8; b++) begin
                op[k][b] = x[b][k];
            end
        end
    end

    // 6 -> 4 -> 3 -> 2 carry-save reduction, then one carry-propagate add.
    assign {c1a, s1a} = csa(op[0], op[1], op[2]);
    assign {c1b, s1b} = csa(op[3], op[4], op[5]);
    assign {c2, s2}   = csa(s1a, c1a, s1b);
    assign {c3, s3}   = csa(s2, c2, c1b);
    assign s          = s3 + c3;
endmodule

module wallace_sum_sequencer #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);
    localparam int TREE_W = 11;
    localparam int SUM_W  = ACC_W + 2;

    typedef enum logic [1:0] {
        COLLECT,
        REDUCE,
        ACCUM,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [5:0][7:0]     slot_q, slot_d;
    logic [2:0]          slot_cnt_q, slot_cnt_d;
    logic [TREE_W-1:0]   tree_q, tree_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [7:0]          count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                last_q, last_d;

    logic [7:0][5:0]     tree_x;
    logic [TREE_W-1:0]   tree_s;
    logic [SUM_W-1:0]    acc_sum;

    // Column b of the tree carries bit b of every slot; empty slots are zero.
    always_comb begin
        tree_x = '0;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 6; k++) begin
                tree_x[b][k] = slot_q[k][b];
            end
        end
    end

    wallace_tree u_tree (
        .x (tree_x),
        .s (tree_s)
    );

    // Two guard bits so even ACC_W=10 sees every carry out of the accumulator.
    assign acc_sum = {2'b00, acc_q} + SUM_W'(tree_q);

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        slot_cnt_d = slot_cnt_q;
        tree_d     = tree_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        last_d     = last_q;

        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    slot_d[slot_cnt_q] = in_data;
                    slot_cnt_d         = slot_cnt_q + 3'd1;
                    count_d            = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    last_d             = in_last;
                    if (slot_cnt_q == 3'd5 || in_last) begin
                        state_d = REDUCE;
                    end
                end
            end
            REDUCE: begin
                tree_d  = tree_s;
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d      = acc_sum[ACC_W-1:0];
                ovf_d      = ovf_q | (|acc_sum[SUM_W-1:ACC_W]);
                slot_d     = '0;
                slot_cnt_d = '0;
                state_d    = last_q ? DONE : COLLECT;
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; the asynchronous reset clears all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            slot_q     <= '0;
            slot_cnt_q <= '0;
            tree_q     <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            slot_cnt_q <= slot_cnt_d;
            tree_q     <= tree_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            last_q     <= last_d;
        end
    end
endmodule

// File: tb/tb_wallace_sum_sequencer.sv
// Self-checking bench: ACC_W=16 and ACC_W=12 instances driven in lockstep, packet
// table plus hand sequences for latency, backpressure and asynchronous reset.

module tb_wallace_sum_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        out_ready = 1'b1;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [15:0] out_sum_a;
    logic [7:0]  out_count_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [11:0] out_sum_b;
    logic [7:0]  out_count_b;

    wallace_sum_sequencer #(.ACC_W(16)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_sum   (out_sum_a),
        .out_count (out_count_a),
        .out_ovf   (out_ovf_a)
    );

    wallace_sum_sequencer #(.ACC_W(12)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_sum   (out_sum_b),
        .out_count (out_count_b),
        .out_ovf   (out_ovf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned sum_a;
        int unsigned count;
        bit          ovf_a;
        int unsigned sum_b;
        bit          ovf_b;
    } exp_t;

    typedef struct {
        int          n;
        int          base;
        int          step;
        int unsigned sum_a;
        int unsigned count;
        bit          ovf_a;
        int unsigned sum_b;
        bit          ovf_b;
        int          stalls;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int n, input int base, input int step);
        longint total = 0;
        exp_t   e;
        for (int i = 0; i < n; i++) begin
            total += (base + i * step) & 255;
        end
        e.sum_a = int'(total % 65536);
        e.ovf_a = (total >= 65536);
        e.sum_b = int'(total % 4096);
        e.ovf_b = (total >= 4096);
        e.count = (n > 255) ? 255 : n;
        return e;
    endfunction

    // Scoreboard consumer: a handshake happens at the posedge after this sample.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n && out_valid_a && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sum_a",   out_sum_a,   e.sum_a);
                check("count_a", out_count_a, e.count);
                check("ovf_a",   out_ovf_a,   e.ovf_a);
                check("valid_b", out_valid_b, 1);
                check("sum_b",   out_sum_b,   e.sum_b);
                check("count_b", out_count_b, e.count);
                check("ovf_b",   out_ovf_b,   e.ovf_b);
            end
        end
    end

    // Called and returning on a negedge; counts negedges spent waiting for in_ready.
    task automatic send_beats(input int n, input int base, input int step,
                              input bit end_pkt, output int stalls);
        int guard;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(base + i * step);
            in_last  = end_pkt && (i == n - 1);
            guard    = 0;
            while (in_ready_a !== 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
                stalls++;
            end
            if (guard >= 200) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((in_ready_a !== 1'b1 || sb.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("idle_reached", guard < 2000, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        exp_t e;
        int   st;
        int   guard;

        vecs[0] = '{8,   200, 7, 1796,  8,   1'b0, 1796, 1'b0, 2};
        vecs[1] = '{1,   255, 0, 255,   1,   1'b0, 255,  1'b0, 0};
        vecs[2] = '{13,  255, 0, 3315,  13,  1'b0, 3315, 1'b0, 4};
        vecs[3] = '{12,  255, 0, 3060,  12,  1'b0, 3060, 1'b0, 2};
        vecs[4] = '{17,  255, 0, 4335,  17,  1'b0, 239,  1'b1, 4};
        vecs[5] = '{7,   0,   0, 0,     7,   1'b0, 0,    1'b0, 2};
        vecs[6] = '{6,   1,   1, 21,    6,   1'b0, 21,   1'b0, 0};
        vecs[7] = '{300, 255, 0, 10964, 255, 1'b1, 2772, 1'b1, 98};
        vecs[8] = '{2,   10,  10, 30,   2,   1'b0, 30,   1'b0, 0};

        repeat (2) @(negedge clk);
        check("rst_in_ready",  in_ready_a,  1);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_sum",   out_sum_a,   0);
        check("rst_out_count", out_count_a, 0);
        check("rst_out_ovf",   out_ovf_a,   0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: last handshake at edge t; valid visible before edge t+3.
        sb.push_back(model(6, 1, 1));
        send_beats(6, 1, 1, 1'b1, st);
        check("lat_valid_t0", out_valid_a, 0);
        check("lat_ready_t0", in_ready_a,  0);
        @(negedge clk);
        check("lat_valid_t1", out_valid_a, 0);
        @(negedge clk);
        check("lat_valid_t2", out_valid_a, 1);
        check("lat_ready_t2", in_ready_a,  0);
        @(negedge clk);
        check("lat_valid_t3", out_valid_a, 0);
        check("lat_ready_t3", in_ready_a,  1);
        wait_idle();

        for (int v = 0; v < 9; v++) begin
            e.sum_a = vecs[v].sum_a;
            e.count = vecs[v].count;
            e.ovf_a = vecs[v].ovf_a;
            e.sum_b = vecs[v].sum_b;
            e.ovf_b = vecs[v].ovf_b;
            sb.push_back(e);
            send_beats(vecs[v].n, vecs[v].base, vecs[v].step, 1'b1, st);
            check($sformatf("stalls_vec%0d", v), st, vecs[v].stalls);
            wait_idle();
        end

        // Backpressure: result held stable while out_ready is low.
        out_ready = 1'b0;
        sb.push_back(model(17, 255, 0));
        send_beats(17, 255, 0, 1'b1, st);
        guard = 0;
        while (out_valid_a !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_valid_seen", out_valid_a, 1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", out_valid_a, 1);
            check("bp_sum_a", out_sum_a,   4335);
            check("bp_count", out_count_a, 17);
            check("bp_ovf_a", out_ovf_a,   0);
            check("bp_sum_b", out_sum_b,   239);
            check("bp_ovf_b", out_ovf_b,   1);
            check("bp_ready", in_ready_a,  0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        sb.push_back(model(2, 10, 10));
        send_beats(2, 10, 10, 1'b1, st);
        wait_idle();

        // Asynchronous reset in the middle of a packet.
        send_beats(3, 40, 1, 1'b0, st);
        check("pre_rst_count", out_count_a, 3);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid_a, 0);
        check("arst_in_ready",  in_ready_a,  1);
        check("arst_out_count", out_count_a, 0);
        check("arst_out_sum",   out_sum_a,   0);
        check("arst_out_ovf",   out_ovf_a,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready_a, 1);
        sb.push_back(model(2, 7, 2));
        send_beats(2, 7, 2, 1'b1, st);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
